// File: rtl/cuppa_regmap_pkg.sv
// Shared constants for the CUPPA register map: window bases, per-channel
// register offsets, global register addresses and the readout FSM states.
package cuppa_regmap_pkg;

   // Address window bases
   localparam logic [3:0] WIN_CHAN = 4'hE;
   localparam logic [7:0] WIN_GLB  = 8'hD0;

   // Per-channel register offsets (y_adr[3:0] inside the channel window)
   localparam logic [3:0] OFF_TRIG_CTRL = 4'h0;
   localparam logic [3:0] OFF_TRIG_THR  = 4'h1;
   localparam logic [3:0] OFF_TRIG_MODE = 4'h2;
   localparam logic [3:0] OFF_CNST_RUN  = 4'h3;
   localparam logic [3:0] OFF_CNST_CONF = 4'h4;
   localparam logic [3:0] OFF_TEST_CONF = 4'h5;
   localparam logic [3:0] OFF_POST_CONF = 4'h6;
   localparam logic [3:0] OFF_PRE_CONF  = 4'h7;
   localparam logic [3:0] OFF_STATUS    = 4'h8;
   localparam logic [3:0] OFF_N_WVF     = 4'h9;
   localparam logic [3:0] OFF_WUSED     = 4'hA;

   // Global register addresses
   localparam logic [11:0] ADR_ARM      = {WIN_GLB, 4'h0};
   localparam logic [11:0] ADR_TRIG_RUN = {WIN_GLB, 4'h1};
   localparam logic [11:0] ADR_WVB_RST  = {WIN_GLB, 4'h2};
   localparam logic [11:0] ADR_DPR_LEN  = {WIN_GLB, 4'h3};
   localparam logic [11:0] ADR_DONE     = {WIN_GLB, 4'h4};
   localparam logic [11:0] ADR_OVF      = {WIN_GLB, 4'h5};
   localparam logic [11:0] ADR_NCHAN    = {WIN_GLB, 4'h6};

   // Readout DPRAM ownership states; encoding is visible on reads of ADR_DONE
   typedef enum logic [1:0] {
      RDOUT_IDLE = 2'd0,
      RDOUT_BUSY = 2'd1
   } rdout_state_e;

endpackage

// File: rtl/cuppa_regmap_n_if.sv
// CRS y-bus: address, write data/strobe from the master, combinational
// read data and hit flag back from the register map.
interface cuppa_regmap_n_if;
   logic [11:0] y_adr;
   logic [15:0] y_wr_data;
   logic        y_wr;
   logic [15:0] y_rd_data;
   logic        y_rd_hit;

   modport master (
      output y_adr, y_wr_data, y_wr,
      input  y_rd_data, y_rd_hit
   );

   modport slave (
      input  y_adr, y_wr_data, y_wr,
      output y_rd_data, y_rd_hit
   );
endinterface

// File: rtl/cuppa_chan_regs.sv
// One channel's trigger / waveform-buffer configuration registers, its
// overflow sticky bit and the readback mux for the channel window.
module cuppa_chan_regs
   import cuppa_regmap_pkg::*;
#(
   parameter int unsigned ADC_BITS = 12,
   parameter int unsigned PRE_W    = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en_i,
   input  logic [3:0]          offset_i,
   input  logic [15:0]         wr_data_i,
   input  logic                ovf_set_i,
   input  logic                ovf_clr_i,
   input  logic                armed_i,
   input  logic                hdr_full_i,
   input  logic [9:0]          n_wvf_i,
   input  logic [15:0]         wused_i,
   output logic                trig_et_o,
   output logic                trig_gt_o,
   output logic                trig_lt_o,
   output logic                thr_en_o,
   output logic                ext_en_o,
   output logic [ADC_BITS-1:0] thr_o,
   output logic                mode_o,
   output logic                cnst_run_o,
   output logic [14:0]         cnst_conf_o,
   output logic [14:0]         test_conf_o,
   output logic [14:0]         post_conf_o,
   output logic [PRE_W-1:0]    pre_conf_o,
   output logic                ovf_o,
   output logic [15:0]         rd_data_o
);

   logic [4:0]          ctrl_q, ctrl_d;
   logic [ADC_BITS-1:0] thr_q, thr_d;
   logic                mode_q, mode_d;
   logic                cnst_run_q, cnst_run_d;
   logic [14:0]         cnst_conf_q, cnst_conf_d;
   logic [14:0]         test_conf_q, test_conf_d;
   logic [14:0]         post_conf_q, post_conf_d;
   logic [PRE_W-1:0]    pre_conf_q, pre_conf_d;
   logic                ovf_q, ovf_d;

   logic unused_wr_data;
   assign unused_wr_data = ^wr_data_i;

   // Next-state: decoded config writes; sticky set dominates W1C clear
   always_comb begin
      ctrl_d      = ctrl_q;
      thr_d       = thr_q;
      mode_d      = mode_q;
      cnst_run_d  = cnst_run_q;
      cnst_conf_d = cnst_conf_q;
      test_conf_d = test_conf_q;
      post_conf_d = post_conf_q;
      pre_conf_d  = pre_conf_q;
      if (wr_en_i) begin
         case (offset_i)
            OFF_TRIG_CTRL: ctrl_d      = wr_data_i[4:0];
            OFF_TRIG_THR:  thr_d       = wr_data_i[ADC_BITS-1:0];
            OFF_TRIG_MODE: mode_d      = wr_data_i[0];
            OFF_CNST_RUN:  cnst_run_d  = wr_data_i[0];
            OFF_CNST_CONF: cnst_conf_d = wr_data_i[14:0];
            OFF_TEST_CONF: test_conf_d = wr_data_i[14:0];
            OFF_POST_CONF: post_conf_d = wr_data_i[14:0];
            OFF_PRE_CONF:  pre_conf_d  = wr_data_i[PRE_W-1:0];
            default: ;
         endcase
      end
      ovf_d = ovf_set_i | (ovf_q & ~ovf_clr_i);
   end

   // Register update with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q      <= '0;
         thr_q       <= '0;
         mode_q      <= 1'b0;
         cnst_run_q  <= 1'b0;
         cnst_conf_q <= '0;
         test_conf_q <= '0;
         post_conf_q <= '0;
         pre_conf_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         ctrl_q      <= ctrl_d;
         thr_q       <= thr_d;
         mode_q      <= mode_d;
         cnst_run_q  <= cnst_run_d;
         cnst_conf_q <= cnst_conf_d;
         test_conf_q <= test_conf_d;
         post_conf_q <= post_conf_d;
         pre_conf_q  <= pre_conf_d;
         ovf_q       <= ovf_d;
      end
   end

   // Readback mux, zero-extended to the bus width
   always_comb begin
      rd_data_o = '0;
      case (offset_i)
         OFF_TRIG_CTRL: rd_data_o = 16'(ctrl_q);
         OFF_TRIG_THR:  rd_data_o = 16'(thr_q);
         OFF_TRIG_MODE: rd_data_o = 16'(mode_q);
         OFF_CNST_RUN:  rd_data_o = 16'(cnst_run_q);
         OFF_CNST_CONF: rd_data_o = 16'(cnst_conf_q);
         OFF_TEST_CONF: rd_data_o = 16'(test_conf_q);
         OFF_POST_CONF: rd_data_o = 16'(post_conf_q);
         OFF_PRE_CONF:  rd_data_o = 16'(pre_conf_q);
         OFF_STATUS:    rd_data_o = 16'({hdr_full_i, ovf_q, armed_i});
         OFF_N_WVF:     rd_data_o = 16'(n_wvf_i);
         OFF_WUSED:     rd_data_o = wused_i;
         default:       rd_data_o = '0;
      endcase
   end

   assign {ext_en_o, thr_en_o, trig_lt_o, trig_gt_o, trig_et_o} = ctrl_q;
   assign thr_o       = thr_q;
   assign mode_o      = mode_q;
   assign cnst_run_o  = cnst_run_q;
   assign cnst_conf_o = cnst_conf_q;
   assign test_conf_o = test_conf_q;
   assign post_conf_o = post_conf_q;
   assign pre_conf_o  = pre_conf_q;
   assign ovf_o       = ovf_q;

endmodule

// File: rtl/cuppa_regmap_n.sv
// CUPPA register map for N digitizer channels: indexed channel window,
// global strobe/mask registers and the readout DPRAM ownership handshake.
module cuppa_regmap_n
   import cuppa_regmap_pkg::*;
#(
   parameter int unsigned N_CHANNELS = 2,
   parameter int unsigned ADC_BITS   = 12,
   parameter int unsigned PRE_W      = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   cuppa_regmap_n_if.slave                ybus,
   output logic [N_CHANNELS-1:0]          trig_et,
   output logic [N_CHANNELS-1:0]          trig_gt,
   output logic [N_CHANNELS-1:0]          trig_lt,
   output logic [N_CHANNELS-1:0]          thresh_trig_en,
   output logic [N_CHANNELS-1:0]          ext_trig_en,
   output logic [N_CHANNELS*ADC_BITS-1:0] trig_thr,
   output logic [N_CHANNELS-1:0]          trig_run,
   output logic [N_CHANNELS-1:0]          wvb_arm,
   output logic [N_CHANNELS-1:0]          trig_mode,
   output logic [N_CHANNELS-1:0]          cnst_run,
   output logic [N_CHANNELS*15-1:0]       cnst_conf,
   output logic [N_CHANNELS*15-1:0]       test_conf,
   output logic [N_CHANNELS*15-1:0]       post_conf,
   output logic [N_CHANNELS*PRE_W-1:0]    pre_conf,
   output logic [N_CHANNELS-1:0]          wvb_rst,
   input  logic [N_CHANNELS-1:0]          wvb_armed,
   input  logic [N_CHANNELS-1:0]          wvb_overflow,
   input  logic [N_CHANNELS-1:0]          wvb_hdr_full,
   input  logic [N_CHANNELS*10-1:0]       wvb_n_wvf,
   input  logic [N_CHANNELS*16-1:0]       wvb_wused,
   input  logic                           rdout_run,
   input  logic [15:0]                    dpram_len_in,
   output logic                           dpram_busy,
   output logic [15:0]                    dpram_len
);

   logic [3:0]            ch;
   logic                  chan_win;
   logic                  ch_valid;
   logic [N_CHANNELS-1:0] chan_wr;
   logic [N_CHANNELS-1:0] ovf_clr;
   logic [N_CHANNELS-1:0] ovf_sticky;
   logic [15:0]           chan_rd [N_CHANNELS];
   logic                  done_wr;

   logic [N_CHANNELS-1:0] wvb_arm_q, wvb_arm_d;
   logic [N_CHANNELS-1:0] trig_run_q, trig_run_d;
   logic [N_CHANNELS-1:0] wvb_rst_q, wvb_rst_d;
   rdout_state_e          state_q, state_d;
   logic                  busy_q, busy_d;
   logic [15:0]           len_q, len_d;

   logic unused_wr_data;
   assign unused_wr_data = ^ybus.y_wr_data;

   assign ch       = ybus.y_adr[7:4];
   assign chan_win = (ybus.y_adr[11:8] == WIN_CHAN);
   assign ch_valid = ({28'd0, ch} < N_CHANNELS);
   assign done_wr  = ybus.y_wr && (ybus.y_adr == ADR_DONE) && ybus.y_wr_data[0];

   // Per-channel write enables and W1C sticky clears
   always_comb begin
      chan_wr = '0;
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
         chan_wr[i] = ybus.y_wr && chan_win && (ch == 4'(i));
      end
      ovf_clr = (ybus.y_wr && (ybus.y_adr == ADR_OVF)) ? ybus.y_wr_data[N_CHANNELS-1:0] : '0;
   end

   for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
      cuppa_chan_regs #(
         .ADC_BITS (ADC_BITS),
         .PRE_W    (PRE_W)
      ) u_chan_regs (
         .clk         (clk),
         .rst         (rst),
         .wr_en_i     (chan_wr[i]),
         .offset_i    (ybus.y_adr[3:0]),
         .wr_data_i   (ybus.y_wr_data),
         .ovf_set_i   (wvb_overflow[i]),
         .ovf_clr_i   (ovf_clr[i]),
         .armed_i     (wvb_armed[i]),
         .hdr_full_i  (wvb_hdr_full[i]),
         .n_wvf_i     (wvb_n_wvf[i*10 +: 10]),
         .wused_i     (wvb_wused[i*16 +: 16]),
         .trig_et_o   (trig_et[i]),
         .trig_gt_o   (trig_gt[i]),
         .trig_lt_o   (trig_lt[i]),
         .thr_en_o    (thresh_trig_en[i]),
         .ext_en_o    (ext_trig_en[i]),
         .thr_o       (trig_thr[i*ADC_BITS +: ADC_BITS]),
         .mode_o      (trig_mode[i]),
         .cnst_run_o  (cnst_run[i]),
         .cnst_conf_o (cnst_conf[i*15 +: 15]),
         .test_conf_o (test_conf[i*15 +: 15]),
         .post_conf_o (post_conf[i*15 +: 15]),
         .pre_conf_o  (pre_conf[i*PRE_W +: PRE_W]),
         .ovf_o       (ovf_sticky[i]),
         .rd_data_o   (chan_rd[i])
      );
   end

   // Global next-state: strobes default low, wvb_rst mask holds until rewritten
   always_comb begin
      wvb_arm_d  = '0;
      trig_run_d = '0;
      wvb_rst_d  = wvb_rst_q;
      if (ybus.y_wr) begin
         case (ybus.y_adr)
            ADR_ARM:      wvb_arm_d  = ybus.y_wr_data[N_CHANNELS-1:0];
            ADR_TRIG_RUN: trig_run_d = ybus.y_wr_data[N_CHANNELS-1:0];
            ADR_WVB_RST:  wvb_rst_d  = ybus.y_wr_data[N_CHANNELS-1:0];
            default: ;
         endcase
      end
   end

   // Global register update
   always_ff @(posedge clk) begin
      if (rst) begin
         wvb_arm_q  <= '0;
         trig_run_q <= '0;
         wvb_rst_q  <= '0;
      end else begin
         wvb_arm_q  <= wvb_arm_d;
         trig_run_q <= trig_run_d;
         wvb_rst_q  <= wvb_rst_d;
      end
   end

   // Readout FSM next-state; in IDLE a run request wins over a done write
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      len_d   = len_q;
      unique case (state_q)
         RDOUT_IDLE: begin
            if (rdout_run) begin
               state_d = RDOUT_BUSY;
               busy_d  = 1'b1;
               len_d   = dpram_len_in;
            end
         end
         RDOUT_BUSY: begin
            if (done_wr) begin
               state_d = RDOUT_IDLE;
               busy_d  = 1'b0;
               len_d   = '0;
            end
         end
         default: begin
            state_d = RDOUT_IDLE;
            busy_d  = 1'b0;
            len_d   = '0;
         end
      endcase
   end

   // Readout FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RDOUT_IDLE;
         busy_q  <= 1'b0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         len_q   <= len_d;
      end
   end

   // Combinational read mux across the channel window and global registers
   always_comb begin
      ybus.y_rd_data = '0;
      ybus.y_rd_hit  = 1'b0;
      if (chan_win) begin
         if (ch_valid) begin
            ybus.y_rd_hit = 1'b1;
            for (int unsigned i = 0; i < N_CHANNELS; i++) begin
               if (ch == 4'(i)) ybus.y_rd_data = chan_rd[i];
            end
         end
      end else begin
         case (ybus.y_adr)
            ADR_ARM, ADR_TRIG_RUN: ybus.y_rd_hit = 1'b1;
            ADR_WVB_RST: begin
               ybus.y_rd_hit  = 1'b1;
               ybus.y_rd_data = 16'(wvb_rst_q);
            end
            ADR_DPR_LEN: begin
               ybus.y_rd_hit  = 1'b1;
               ybus.y_rd_data = len_q;
            end
            ADR_DONE: begin
               ybus.y_rd_hit  = 1'b1;
               ybus.y_rd_data = {14'b0, state_q};
            end
            ADR_OVF: begin
               ybus.y_rd_hit  = 1'b1;
               ybus.y_rd_data = 16'(ovf_sticky);
            end
            ADR_NCHAN: begin
               ybus.y_rd_hit  = 1'b1;
               ybus.y_rd_data = 16'(N_CHANNELS);
            end
            default: ;
         endcase
      end
   end

   assign wvb_arm    = wvb_arm_q;
   assign trig_run   = trig_run_q;
   assign wvb_rst    = wvb_rst_q;
   assign dpram_busy = busy_q;
   assign dpram_len  = len_q;

endmodule

// File: tb/tb_cuppa_regmap_n.sv
// Directed self-checking bench for cuppa_regmap_n with four channels.
module tb_cuppa_regmap_n;

   localparam int unsigned N  = 4;
   localparam int unsigned AB = 12;
   localparam int unsigned PW = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cuppa_regmap_n_if ybus ();

   logic [N-1:0]    trig_et, trig_gt, trig_lt, thresh_trig_en, ext_trig_en;
   logic [N*AB-1:0] trig_thr;
   logic [N-1:0]    trig_run, wvb_arm, trig_mode, cnst_run, wvb_rst;
   logic [N*15-1:0] cnst_conf, test_conf, post_conf;
   logic [N*PW-1:0] pre_conf;
   logic [N-1:0]    wvb_armed, wvb_overflow, wvb_hdr_full;
   logic [N*10-1:0] wvb_n_wvf;
   logic [N*16-1:0] wvb_wused;
   logic            rdout_run;
   logic [15:0]     dpram_len_in;
   logic            dpram_busy;
   logic [15:0]     dpram_len;

   int n_cmp = 0;
   int n_bad = 0;

   cuppa_regmap_n #(
      .N_CHANNELS (N),
      .ADC_BITS   (AB),
      .PRE_W      (PW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ybus           (ybus),
      .trig_et        (trig_et),
      .trig_gt        (trig_gt),
      .trig_lt        (trig_lt),
      .thresh_trig_en (thresh_trig_en),
      .ext_trig_en    (ext_trig_en),
      .trig_thr       (trig_thr),
      .trig_run       (trig_run),
      .wvb_arm        (wvb_arm),
      .trig_mode      (trig_mode),
      .cnst_run       (cnst_run),
      .cnst_conf      (cnst_conf),
      .test_conf      (test_conf),
      .post_conf      (post_conf),
      .pre_conf       (pre_conf),
      .wvb_rst        (wvb_rst),
      .wvb_armed      (wvb_armed),
      .wvb_overflow   (wvb_overflow),
      .wvb_hdr_full   (wvb_hdr_full),
      .wvb_n_wvf      (wvb_n_wvf),
      .wvb_wused      (wvb_wused),
      .rdout_run      (rdout_run),
      .dpram_len_in   (dpram_len_in),
      .dpram_busy     (dpram_busy),
      .dpram_len      (dpram_len)
   );

   // One-cycle bus write; returns on the negedge after the write edge
   task automatic bus_write(input logic [11:0] adr, input logic [15:0] data);
      @(negedge clk);
      ybus.y_adr     = adr;
      ybus.y_wr_data = data;
      ybus.y_wr      = 1'b1;
      @(negedge clk);
      ybus.y_wr      = 1'b0;
   endtask

   task automatic bus_addr(input logic [11:0] adr);
      ybus.y_adr = adr;
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (trig_thr !== '0) begin n_bad++;
         $display("FAIL rst_thr: got %h want 0", trig_thr); end
      n_cmp++; if (dpram_busy !== 1'b0 || dpram_len !== 16'h0) begin n_bad++;
         $display("FAIL rst_dpram: got %b/%h want 0/0000", dpram_busy, dpram_len); end
      n_cmp++; if (wvb_arm !== 4'h0 || wvb_rst !== 4'h0) begin n_bad++;
         $display("FAIL rst_masks: got %h/%h want 0/0", wvb_arm, wvb_rst); end
      bus_addr(12'hD04);
      n_cmp++; if (ybus.y_rd_data !== 16'h0 || ybus.y_rd_hit !== 1'b1) begin n_bad++;
         $display("FAIL rst_d04: got %h hit %b want 0000 hit 1", ybus.y_rd_data, ybus.y_rd_hit); end
      bus_addr(12'hD06);
      n_cmp++; if (ybus.y_rd_data !== 16'h0004) begin n_bad++;
         $display("FAIL nchan: got %h want 0004", ybus.y_rd_data); end
   endtask

   task automatic test_chan_rw();
      bus_write(12'hE11, 16'h0ABC);
      n_cmp++; if (trig_thr !== 48'h000000ABC000) begin n_bad++;
         $display("FAIL thr_ch1: got %h want 000000abc000", trig_thr); end
      bus_addr(12'hE11);
      n_cmp++; if (ybus.y_rd_data !== 16'h0ABC) begin n_bad++;
         $display("FAIL rd_e11: got %h want 0abc", ybus.y_rd_data); end
      bus_addr(12'hE01);
      n_cmp++; if (ybus.y_rd_data !== 16'h0000) begin n_bad++;
         $display("FAIL rd_e01: got %h want 0000", ybus.y_rd_data); end
      bus_write(12'hE10, 16'hFFFF);
      n_cmp++; if ({ext_trig_en, thresh_trig_en, trig_lt, trig_gt, trig_et} !== 20'h22222) begin
         n_bad++; $display("FAIL ctrl_ch1: got %h want 22222",
            {ext_trig_en, thresh_trig_en, trig_lt, trig_gt, trig_et}); end
      bus_addr(12'hE10);
      n_cmp++; if (ybus.y_rd_data !== 16'h001F) begin n_bad++;
         $display("FAIL rd_e10: got %h want 001f", ybus.y_rd_data); end
      bus_write(12'hE34, 16'hFFFF);
      n_cmp++; if (cnst_conf !== {15'h7FFF, 45'd0}) begin n_bad++;
         $display("FAIL cnst_ch3: got %h want 7fff<<45", cnst_conf); end
      bus_write(12'hE07, 16'hFFFF);
      bus_addr(12'hE07);
      n_cmp++; if (pre_conf !== 24'h00003F || ybus.y_rd_data !== 16'h003F) begin n_bad++;
         $display("FAIL pre_ch0: got %h/%h want 00003f/003f", pre_conf, ybus.y_rd_data); end
      bus_write(12'hE22, 16'h0003);
      bus_addr(12'hE22);
      n_cmp++; if (trig_mode !== 4'b0100 || ybus.y_rd_data !== 16'h0001) begin n_bad++;
         $display("FAIL mode_ch2: got %b/%h want 0100/0001", trig_mode, ybus.y_rd_data); end
      bus_addr(12'hE0B);
      n_cmp++; if (ybus.y_rd_data !== 16'h0 || ybus.y_rd_hit !== 1'b1) begin n_bad++;
         $display("FAIL rd_e0b: got %h hit %b want 0000 hit 1", ybus.y_rd_data, ybus.y_rd_hit); end
   endtask

   task automatic test_status();
      wvb_armed    = 4'b0001;
      wvb_hdr_full = 4'b0001;
      wvb_n_wvf    = {10'h3FF, 30'd0};
      wvb_wused    = {16'h0, 16'hBEEF, 32'h0};
      bus_addr(12'hE08);
      n_cmp++; if (ybus.y_rd_data !== 16'h0005) begin n_bad++;
         $display("FAIL stat_ch0: got %h want 0005", ybus.y_rd_data); end
      bus_addr(12'hE39);
      n_cmp++; if (ybus.y_rd_data !== 16'h03FF) begin n_bad++;
         $display("FAIL nwvf_ch3: got %h want 03ff", ybus.y_rd_data); end
      bus_addr(12'hE2A);
      n_cmp++; if (ybus.y_rd_data !== 16'hBEEF) begin n_bad++;
         $display("FAIL wused_ch2: got %h want beef", ybus.y_rd_data); end
   endtask

   task automatic test_strobe();
      n_cmp++; if (wvb_arm !== 4'h0 || trig_run !== 4'h0) begin n_bad++;
         $display("FAIL strb_idle: got %b/%b want 0000/0000", wvb_arm, trig_run); end
      bus_write(12'hD00, 16'h0005);
      bus_addr(12'hD00);
      n_cmp++; if (wvb_arm !== 4'b0101 || trig_run !== 4'h0) begin n_bad++;
         $display("FAIL arm_on: got %b/%b want 0101/0000", wvb_arm, trig_run); end
      n_cmp++; if (ybus.y_rd_data !== 16'h0) begin n_bad++;
         $display("FAIL rd_d00: got %h want 0000", ybus.y_rd_data); end
      @(negedge clk);
      n_cmp++; if (wvb_arm !== 4'h0) begin n_bad++;
         $display("FAIL arm_off: got %b want 0000", wvb_arm); end
      bus_write(12'hD01, 16'h00F3);
      n_cmp++; if (trig_run !== 4'b0011) begin n_bad++;
         $display("FAIL run_on: got %b want 0011", trig_run); end
      @(negedge clk);
      n_cmp++; if (trig_run !== 4'h0) begin n_bad++;
         $display("FAIL run_off: got %b want 0000", trig_run); end
      bus_write(12'hD02, 16'hFFFF);
      bus_addr(12'hD02);
      n_cmp++; if (wvb_rst !== 4'hF || ybus.y_rd_data !== 16'h000F) begin n_bad++;
         $display("FAIL wvb_rst: got %h/%h want f/000f", wvb_rst, ybus.y_rd_data); end
   endtask

   task automatic test_out_of_range();
      bus_write(12'hE51, 16'h0FFF);
      bus_write(12'hE54, 16'h7FFF);
      bus_addr(12'hE51);
      n_cmp++; if (trig_thr !== 48'h000000ABC000 || cnst_conf !== {15'h7FFF, 45'd0}) begin
         n_bad++; $display("FAIL oor_wr: got %h/%h want unchanged", trig_thr, cnst_conf); end
      n_cmp++; if (ybus.y_rd_hit !== 1'b0 || ybus.y_rd_data !== 16'h0) begin n_bad++;
         $display("FAIL oor_e51: got %h hit %b want 0000 hit 0", ybus.y_rd_data, ybus.y_rd_hit); end
      bus_addr(12'hE41);
      n_cmp++; if (ybus.y_rd_hit !== 1'b0) begin n_bad++;
         $display("FAIL oor_e41: got hit %b want 0", ybus.y_rd_hit); end
      bus_addr(12'hD07);
      n_cmp++; if (ybus.y_rd_hit !== 1'b0) begin n_bad++;
         $display("FAIL hit_d07: got hit %b want 0", ybus.y_rd_hit); end
   endtask

   task automatic test_overflow();
      @(negedge clk);
      wvb_overflow = 4'b0100;
      @(negedge clk);
      wvb_overflow = 4'b0000;
      bus_addr(12'hE28);
      n_cmp++; if (ybus.y_rd_data !== 16'h0002) begin n_bad++;
         $display("FAIL ovf_set: got %h want 0002", ybus.y_rd_data); end
      bus_addr(12'hD05);
      n_cmp++; if (ybus.y_rd_data !== 16'h0004) begin n_bad++;
         $display("FAIL rd_d05: got %h want 0004", ybus.y_rd_data); end
      @(negedge clk);
      wvb_overflow   = 4'b0100;
      ybus.y_adr     = 12'hD05;
      ybus.y_wr_data = 16'h0004;
      ybus.y_wr      = 1'b1;
      @(negedge clk);
      wvb_overflow = 4'b0000;
      ybus.y_wr    = 1'b0;
      bus_addr(12'hE28);
      n_cmp++; if (ybus.y_rd_data !== 16'h0002) begin n_bad++;
         $display("FAIL ovf_setwins: got %h want 0002", ybus.y_rd_data); end
      bus_write(12'hD05, 16'h0004);
      bus_addr(12'hE28);
      n_cmp++; if (ybus.y_rd_data !== 16'h0000) begin n_bad++;
         $display("FAIL ovf_clr: got %h want 0000", ybus.y_rd_data); end
   endtask

   task automatic test_readout();
      @(negedge clk);
      rdout_run = 1'b1; dpram_len_in = 16'h0123;
      @(negedge clk);
      rdout_run = 1'b0;
      bus_addr(12'hD03);
      n_cmp++; if (dpram_busy !== 1'b1 || ybus.y_rd_data !== 16'h0123) begin n_bad++;
         $display("FAIL run1: got %b/%h want 1/0123", dpram_busy, ybus.y_rd_data); end
      bus_addr(12'hD04);
      n_cmp++; if (ybus.y_rd_data !== 16'h0001) begin n_bad++;
         $display("FAIL rd_busy: got %h want 0001", ybus.y_rd_data); end
      @(negedge clk);
      rdout_run = 1'b1; dpram_len_in = 16'h0456;
      @(negedge clk);
      rdout_run = 1'b0;
      n_cmp++; if (dpram_busy !== 1'b1 || dpram_len !== 16'h0123) begin n_bad++;
         $display("FAIL run2_ign: got %b/%h want 1/0123", dpram_busy, dpram_len); end
      bus_write(12'hD04, 16'h0001);
      bus_addr(12'hD04);
      n_cmp++; if (dpram_busy !== 1'b0 || dpram_len !== 16'h0 || ybus.y_rd_data !== 16'h0)
         begin n_bad++; $display("FAIL done: got %b/%h/%h want 0/0000/0000",
            dpram_busy, dpram_len, ybus.y_rd_data); end
      bus_write(12'hD04, 16'h0001);
      n_cmp++; if (dpram_busy !== 1'b0) begin n_bad++;
         $display("FAIL done_idle: got %b want 0", dpram_busy); end
      @(negedge clk);
      rdout_run = 1'b1; dpram_len_in = 16'h0077;
      ybus.y_adr = 12'hD04; ybus.y_wr_data = 16'h0001; ybus.y_wr = 1'b1;
      @(negedge clk);
      rdout_run = 1'b0; ybus.y_wr = 1'b0;
      n_cmp++; if (dpram_busy !== 1'b1 || dpram_len !== 16'h0077) begin n_bad++;
         $display("FAIL run_wins: got %b/%h want 1/0077", dpram_busy, dpram_len); end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      wvb_overflow = 4'b0001;
      @(negedge clk);
      wvb_overflow = 4'b0000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (dpram_busy !== 1'b0 || dpram_len !== 16'h0) begin n_bad++;
         $display("FAIL rb_dpram: got %b/%h want 0/0000", dpram_busy, dpram_len); end
      n_cmp++; if (trig_thr !== '0 || cnst_conf !== '0 || pre_conf !== '0) begin n_bad++;
         $display("FAIL rb_cfg: got %h/%h/%h want 0", trig_thr, cnst_conf, pre_conf); end
      n_cmp++; if ({trig_mode, wvb_rst, wvb_arm, trig_run, trig_et, ext_trig_en} !== 24'h0)
         begin n_bad++; $display("FAIL rb_bits: got %b/%b want 0000/0000",
            trig_mode, wvb_rst); end
      bus_addr(12'hD04);
      n_cmp++; if (ybus.y_rd_data !== 16'h0) begin n_bad++;
         $display("FAIL rb_d04: got %h want 0000", ybus.y_rd_data); end
      bus_addr(12'hD05);
      n_cmp++; if (ybus.y_rd_data !== 16'h0) begin n_bad++;
         $display("FAIL rb_d05: got %h want 0000", ybus.y_rd_data); end
   endtask

   initial begin
      ybus.y_adr     = '0;
      ybus.y_wr_data = '0;
      ybus.y_wr      = 1'b0;
      wvb_armed      = '0;
      wvb_overflow   = '0;
      wvb_hdr_full   = '0;
      wvb_n_wvf      = '0;
      wvb_wused      = '0;
      rdout_run      = 1'b0;
      dpram_len_in   = '0;
      test_reset();
      test_chan_rw();
      test_status();
      test_strobe();
      test_out_of_range();
      test_overflow();
      test_readout();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
